// File: rtl/mpmc10_req_arbiter.sv
// Round-robin arbiter that pops one command request from the mpmc10 port FIFOs
// and presents it to the controller state machine over a valid/ready handshake.
module mpmc10_req_arbiter #(
    parameter int NPORT = 8,
    parameter int RW    = 320,
    parameter int TMO   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORT-1:0]         en,
    input  logic [NPORT-1:0]         empty,
    input  logic [NPORT-1:0]         rd_rst_busy,
    input  logic [NPORT-1:0]         v,
    input  logic [NPORT*RW-1:0]      req_fifoo,
    output logic [NPORT-1:0]         rd_fifo,
    output logic [RW-1:0]            req_o,
    output logic                     req_v,
    input  logic                     req_rdy,
    output logic [$clog2(NPORT)-1:0] port_o,
    output logic                     busy,
    output logic                     err
);

    localparam int PW = $clog2(NPORT);
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] POP  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    sel_q, sel_d;
    logic [PW-1:0]    last_q, last_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [NPORT-1:0] rd_fifo_q, rd_fifo_d;
    logic [RW-1:0]    req_q, req_d;
    logic             req_v_q, req_v_d;
    logic [PW-1:0]    port_q, port_d;
    logic             err_q, err_d;

    logic [NPORT-1:0] elig;
    logic             pick_found;
    logic [PW-1:0]    pick_port;
    logic [PW-1:0]    cand;
    logic [RW-1:0]    sel_word;

    assign elig = en & ~empty & ~rd_rst_busy;

    // Search starts one past the last granted port so every port gets a turn.
    always_comb begin
        pick_found = 1'b0;
        pick_port  = '0;
        cand       = '0;
        for (int i = 1; i <= NPORT; i++) begin
            cand = PW'((int'(last_q) + i) % NPORT);
            if (!pick_found && elig[cand]) begin
                pick_found = 1'b1;
                pick_port  = cand;
            end
        end
    end

    always_comb begin
        sel_word = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (sel_q == PW'(p)) begin
                sel_word = req_fifoo[p*RW +: RW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        timer_d   = timer_q;
        rd_fifo_d = '0;
        req_d     = req_q;
        req_v_d   = req_v_q;
        port_d    = port_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    sel_d                = pick_port;
                    rd_fifo_d[pick_port] = 1'b1;
                    state_d              = POP;
                end
            end
            POP: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Only the selected port's data_valid matters; a missing one is a lost pop.
                if (v[sel_q]) begin
                    req_d   = sel_word;
                    port_d  = sel_q;
                    req_v_d = 1'b1;
                    state_d = HOLD;
                end else if (timer_q == TW'(TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            HOLD: begin
                if (req_rdy) begin
                    req_v_d = 1'b0;
                    last_d  = sel_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            last_q    <= PW'(NPORT - 1);
            timer_q   <= '0;
            rd_fifo_q <= '0;
            req_q     <= '0;
            req_v_q   <= 1'b0;
            port_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
            rd_fifo_q <= rd_fifo_d;
            req_q     <= req_d;
            req_v_q   <= req_v_d;
            port_q    <= port_d;
            err_q     <= err_d;
        end
    end

    assign rd_fifo = rd_fifo_q;
    assign req_o   = req_q;
    assign req_v   = req_v_q;
    assign port_o  = port_q;
    assign err     = err_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: doc/mpmc10_req_arbiter.md
Name: mpmc10_req_arbiter

Overview:
- Downstream of the per-port command FIFOs in the mpmc10 memory controller.
- Round-robin selects one non-empty port FIFO, pops one command request, registers it, and presents it to the controller state machine with a valid/ready handshake.
- Only this block drives the FIFO read enables, so a FIFO it sees as non-empty cannot become empty before it pops that FIFO.

Parameters:
- NPORT, 8: number of port FIFOs arbitrated (2..16).
- RW, 320: width in bits of one packed command request word, equal to the FIFO read data width.
- TMO, 4: cycles to wait for FIFO data_valid after a pop before declaring an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  NPORT  per-port arbitration enable; 0 masks the port.
- empty  in  NPORT  per-port FIFO empty flag.
- rd_rst_busy  in  NPORT  per-port FIFO read-reset-busy flag.
- v  in  NPORT  per-port FIFO data_valid (read latency 1).
- req_fifoo  in  NPORT*RW  concatenated FIFO outputs; port p occupies bits [p*RW +: RW].
- rd_fifo  out  NPORT  per-port FIFO read enable (registered, one-hot or zero).
- req_o  out  RW  captured request.
- req_v  out  1  req_o valid.
- req_rdy  in  1  controller accepts req_o.
- port_o  out  $clog2(NPORT)  port number of req_o.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky data_valid timeout flag.

Behaviour:
- Eligible port p: en[p] & ~empty[p] & ~rd_rst_busy[p].
- Round-robin search order: last+1, last+2, … mod NPORT, where last is the last granted port. The first eligible port in that order is selected.

States:
- IDLE
  - If any port is eligible: sel <= chosen port; rd_fifo <= onehot(sel); go to POP.
  - Otherwise stay in IDLE with rd_fifo = 0.
- POP
  - rd_fifo is high for exactly this one cycle, then rd_fifo <= 0.
  - Timer <= 0; go to WAIT.
- WAIT
  - If v[sel]: req_o <= req_fifoo[sel*RW +: RW]; port_o <= sel; req_v <= 1; go to HOLD.
  - Otherwise increment the timer. When the timer reaches TMO-1: err <= 1 and go to IDLE with no request issued.
  - v on ports other than sel is ignored.
- HOLD
  - req_v and req_o are held stable until req_rdy is high at a clock edge.
  - At that edge: req_v <= 0; last <= sel; go to IDLE.

Latency and throughput:
- Eligibility at cycle 0 gives rd_fifo at cycle 1, v at cycle 2, and req_v at cycle 3.
- The minimum issue interval is 4 cycles per request when req_rdy is tied high.

Masking and port changes:
- en and rd_rst_busy are sampled only in IDLE.
- Deasserting them after selection does not abort the grant in progress.

Reset:
- rst applies in any state, including mid-POP or mid-HOLD.
- Reset values: state=IDLE, rd_fifo=0, req_v=0, req_o=0, port_o=0, busy=0, err=0, last=NPORT-1 (so port 0 wins first).
- A popped request that is in flight during reset is discarded.
- req_rdy while req_v=0 is ignored.

Test Plan:
- After reset, ports 2 and 5 non-empty, req_rdy=1 -> rd_fifo=8'h04 at cycle 1, req_v at cycle 3 with port_o=2; the next grant is port 5 with rd_fifo=8'h20, then port 2 again.
- All 8 ports continuously non-empty, req_rdy=1, 32 grants -> port_o sequence 0..7 repeated 4 times; rd_fifo never has more than one bit set.
- Single port 3 holding 3 entries, req_rdy low for 10 cycles in HOLD -> req_v and req_o stay stable and no further rd_fifo pulse occurs; 3 requests issue in FIFO order once req_rdy=1.
- Port 1 with en[1]=0 and rd_rst_busy[4]=1, ports 1, 4 and 6 non-empty -> only port 6 is granted; port 1 is granted after en[1] rises.
- v[sel] withheld after a pop, with TMO=4 -> err=1 four cycles after entering WAIT, state returns to IDLE, req_v never asserts, and err stays 1 until rst.
- rst asserted in HOLD with req_v=1 -> on the next cycle req_v=0, rd_fifo=0, busy=0, err=0; the first grant afterwards goes to the lowest eligible port.
